// File: rtl/ser_pkg.sv
// Shared definitions for the bit-serial feeder.
//   state_t      : feeder state (IDLE, SHIFT)
//   IDLE_BIT_DEF : default level driven on the serial output when no bit is valid
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic IDLE_BIT_DEF = 1'b0;

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Parallel word handshake into the serial bit feeder.
//   in_data  : word to serialize (WIDTH bits)
//   in_valid : in_data is valid
//   in_ready : feeder can accept a word this cycle
// Modports: master = word producer, slave = feeder.
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
) ();

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/serial_bit_feeder.sv
// Serial bit feeder: accepts parallel words over a valid/ready handshake and
// shifts them out one bit per clock on x_out, which drives a bit-serial
// sequence detector's x input. A one-word holding register lets consecutive
// words stream with no idle bit between them.
//
// Ports:
//   clk       : clock
//   rst       : asynchronous reset, active-high
//   bus       : slave side of serial_bit_feeder_if (in_data/in_valid/in_ready)
//   x_out     : serial bit (IDLE_BIT when no bit is valid)
//   bit_valid : x_out carries a data bit
//   first_bit : x_out is the first bit of a word
//   last_bit  : x_out is the last bit of a word
//   busy      : a word is in the shifter or the holding register
//
// Build option: define SER_LSB_FIRST_EN to emit bit 0 first; by default the
// MSB is emitted first. Handshake, timing and flags are the same either way.
module serial_bit_feeder
    import ser_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = IDLE_BIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    serial_bit_feeder_if.slave  bus,
    output logic                x_out,
    output logic                bit_valid,
    output logic                first_bit,
    output logic                last_bit,
    output logic                busy
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;        // bits remaining after the one on x_out
    logic [WIDTH-1:0] sreg;       // remaining bits, next bit in the lead position
    logic [WIDTH-1:0] hold;
    logic             hold_full;

    logic             xfer;
    logic             last_now;
    logic             load;
    logic             capture;
    logic [WIDTH-1:0] load_word;

    // Bit that leaves the word first.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
`ifdef SER_LSB_FIRST_EN
        return w[0];
`else
        return w[WIDTH-1];
`endif
    endfunction

    // Word with its lead bit consumed.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
`ifdef SER_LSB_FIRST_EN
        return w >> 1;
`else
        return w << 1;
`endif
    endfunction

    // in_ready depends only on registered state, never on in_valid.
    assign bus.in_ready = !hold_full;
    assign xfer         = bus.in_valid && !hold_full;
    assign last_now     = (state == SHIFT) && (cnt == '0);

    // A new word enters the shifter from idle, or at the last bit of the
    // current word; the held word has priority over the bus.
    assign load      = ((state == IDLE) && xfer) || (last_now && (hold_full || xfer));
    assign load_word = hold_full ? hold : bus.in_data;
    assign capture   = (state == SHIFT) && (cnt != '0) && xfer;

    // Data path: shifter and holding register carry no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            sreg <= advance(load_word);
        end else if (state == SHIFT) begin
            sreg <= advance(sreg);
        end
        if (capture) begin
            hold <= bus.in_data;
        end
    end

    // Control and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hold_full <= 1'b0;
            x_out     <= IDLE_BIT;
            bit_valid <= 1'b0;
            first_bit <= 1'b0;
            last_bit  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        x_out     <= lead_bit(bus.in_data);
                        cnt       <= CNT_W'(WIDTH - 1);
                        bit_valid <= 1'b1;
                        first_bit <= 1'b1;
                        last_bit  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        x_out     <= lead_bit(sreg);
                        cnt       <= cnt - 1'b1;
                        first_bit <= 1'b0;
                        last_bit  <= (cnt == CNT_W'(1));
                        if (xfer) begin
                            hold_full <= 1'b1;
                        end
                    end else if (hold_full || xfer) begin
                        // Back-to-back handover: next word's first bit follows
                        // the last bit directly.
                        x_out     <= lead_bit(load_word);
                        cnt       <= CNT_W'(WIDTH - 1);
                        first_bit <= 1'b1;
                        last_bit  <= 1'b0;
                        hold_full <= 1'b0;
                    end else begin
                        x_out     <= IDLE_BIT;
                        bit_valid <= 1'b0;
                        first_bit <= 1'b0;
                        last_bit  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Self-checking bench for serial_bit_feeder (default MSB-first build).
// Main instance WIDTH=8 driven from a vector table; a second WIDTH=2 instance
// and a mid-word reset are exercised with hand-written sequences.
// Observed vector per check: {in_ready, x_out, bit_valid, first_bit, last_bit, busy}.
module tb_serial_bit_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_bit_feeder_if #(.WIDTH(8)) bus ();
    serial_bit_feeder_if #(.WIDTH(2)) bus2 ();

    logic x_out, bit_valid, first_bit, last_bit, busy;
    logic x2, bv2, fb2, lb2, busy2;

    serial_bit_feeder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .x_out     (x_out),
        .bit_valid (bit_valid),
        .first_bit (first_bit),
        .last_bit  (last_bit),
        .busy      (busy)
    );

    serial_bit_feeder #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2),
        .x_out     (x2),
        .bit_valid (bv2),
        .first_bit (fb2),
        .last_bit  (lb2),
        .busy      (busy2)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    localparam logic [5:0] IDLE_EXP = 6'b100000;

    function automatic logic [5:0] obs();
        return {bus.in_ready, x_out, bit_valid, first_bit, last_bit, busy};
    endfunction

    function automatic logic [5:0] obs2();
        return {bus2.in_ready, x2, bv2, fb2, lb2, busy2};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got {rdy,x,bv,fb,lb,busy}=%b expected %b", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic [5:0] exp, input string name);
        vec_t r;
        r.v = v; r.d = d; r.exp = exp; r.name = name;
        q.push_back(r);
    endtask

    // Rows for bit positions lo..hi of word w (MSB first), with the given
    // bus inputs held and the given in_ready expected after each edge.
    task automatic bitrows(input logic [7:0] w, input int lo, input int hi,
                           input logic v, input logic [7:0] d, input logic rdy,
                           input string name);
        for (int i = lo; i <= hi; i++)
            add(v, d, {rdy, w[7-i], 1'b1, (i == 0), (i == 7), 1'b1}, $sformatf("%s_b%0d", name, i));
    endtask

    initial begin
        vec_t w2[5];

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus2.in_valid = 1'b0;
        bus2.in_data  = 2'b00;

        // Single word 0x79 -> 0,1,1,1,1,0,0,1 then idle.
        bitrows(8'h79, 0, 0, 1'b1, 8'h79, 1'b1, "single");
        bitrows(8'h79, 1, 7, 1'b0, 8'h00, 1'b1, "single");
        add(1'b0, 8'h00, IDLE_EXP, "single_idle");

        // Back-to-back 0xFF then 0x39: 16 bits with no gap.
        bitrows(8'hFF, 0, 0, 1'b1, 8'hFF, 1'b1, "b2b_ff");
        bitrows(8'hFF, 1, 1, 1'b1, 8'h39, 1'b0, "b2b_ff");
        bitrows(8'hFF, 2, 7, 1'b0, 8'h00, 1'b0, "b2b_ff");
        bitrows(8'h39, 0, 7, 1'b0, 8'h00, 1'b1, "b2b_39");
        add(1'b0, 8'h00, IDLE_EXP, "b2b_idle");

        // Backpressure: A5, 3C, 96 offered continuously.
        bitrows(8'hA5, 0, 0, 1'b1, 8'hA5, 1'b1, "bp_a5");
        bitrows(8'hA5, 1, 1, 1'b1, 8'h3C, 1'b0, "bp_a5");
        bitrows(8'hA5, 2, 7, 1'b1, 8'h96, 1'b0, "bp_a5");
        bitrows(8'h3C, 0, 0, 1'b1, 8'h96, 1'b1, "bp_3c");
        bitrows(8'h3C, 1, 1, 1'b1, 8'h96, 1'b0, "bp_3c");
        bitrows(8'h3C, 2, 7, 1'b0, 8'h00, 1'b0, "bp_3c");
        bitrows(8'h96, 0, 7, 1'b0, 8'h00, 1'b1, "bp_96");
        add(1'b0, 8'h00, IDLE_EXP, "bp_idle");

        // Idle gap: 0x80, three idle cycles, 0x01.
        bitrows(8'h80, 0, 0, 1'b1, 8'h80, 1'b1, "gap_80");
        bitrows(8'h80, 1, 7, 1'b0, 8'h00, 1'b1, "gap_80");
        for (int i = 0; i < 3; i++)
            add(1'b0, 8'h00, IDLE_EXP, $sformatf("gap_idle%0d", i));
        bitrows(8'h01, 0, 0, 1'b1, 8'h01, 1'b1, "gap_01");
        bitrows(8'h01, 1, 7, 1'b0, 8'h00, 1'b1, "gap_01");
        add(1'b0, 8'h00, IDLE_EXP, "gap_end");

        // Reset state of both instances.
        #12;
        check("reset_w8", obs(), IDLE_EXP);
        check("reset_w2", obs2(), IDLE_EXP);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven part.
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            bus.in_valid = q[i].v;
            bus.in_data  = q[i].d;
            @(posedge clk);
            #1;
            check(q[i].name, obs(), q[i].exp);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;

        // Reset during the fourth bit of 0xF0, then a clean restart with 0xC3.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hF0;
        @(posedge clk); #1;
        check("rst_f0_b0", obs(), 6'b111101);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_f0_b3", obs(), 6'b111001);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async", obs(), IDLE_EXP);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_held_idle", obs(), IDLE_EXP);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC3;
        @(posedge clk); #1;
        check("restart_b0", obs(), 6'b111101);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("restart_b1", obs(), 6'b111001);
        @(posedge clk); #1;
        check("restart_b2", obs(), 6'b101001);
        repeat (6) @(posedge clk);
        #1;
        check("restart_idle", obs(), IDLE_EXP);

        // WIDTH=2: 2'b10 then 2'b01 back-to-back -> 1,0,0,1.
        w2[0] = '{1'b1, 8'h02, 6'b111101, "w2_b0"};
        w2[1] = '{1'b1, 8'h01, 6'b001011, "w2_b1"};
        w2[2] = '{1'b0, 8'h00, 6'b101101, "w2_b2"};
        w2[3] = '{1'b0, 8'h00, 6'b111011, "w2_b3"};
        w2[4] = '{1'b0, 8'h00, IDLE_EXP,  "w2_idle"};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus2.in_valid = w2[i].v;
            bus2.in_data  = w2[i].d[1:0];
            @(posedge clk);
            #1;
            check(w2[i].name, obs2(), w2[i].exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
Upstream stage of the bit-serial sequence detectors. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on x_out, which drives the detector's x input directly. A one-word holding register lets back-to-back words stream with no idle gap. When no word is in flight, it drives a defined idle level.

Parameters:
WIDTH, 8, bits per input word; legal range WIDTH >= 2.
IDLE_BIT, 1'b0, level driven on x_out when no bit is valid.

Ports:
clk  input  1  clock
rst  input  1  reset
in_data  input  WIDTH  parallel word to serialize
in_valid  input  1  in_data is valid
in_ready  output  1  feeder can accept a word this cycle
x_out  output  1  serial bit to detector x
bit_valid  output  1  x_out carries a data bit (not idle)
first_bit  output  1  x_out is the first bit of a word
last_bit  output  1  x_out is the last bit of a word
busy  output  1  word in shifter or holding register

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. On reset: x_out=IDLE_BIT; bit_valid, first_bit, last_bit and busy = 0; hold_full=0; state IDLE; cnt=0.
- Reset mid-word discards the shifter and hold contents. x_out returns to IDLE_BIT immediately (asynchronous).
- Transfer occurs on a rising edge when in_valid && in_ready. in_ready = !hold_full (register-driven, no combinational path from in_valid).
- All outputs except in_ready are registered. busy = (state==SHIFT) || hold_full.
- Bit order is MSB first by default.
- Latency: a word accepted at edge N (feeder IDLE) puts bit WIDTH-1 on x_out from edge N until edge N+1. Its last bit occupies the cycle after edge N+WIDTH-1.
- State machine, 2 states; cnt is $clog2(WIDTH) bits and counts bits remaining after the current one.
- IDLE:
  - On transfer: x_out<=in_data[WIDTH-1]; sreg<=in_data shifted left 1; cnt<=WIDTH-1; bit_valid<=1; first_bit<=1; go SHIFT.
  - Otherwise hold idle outputs.
- SHIFT, cnt!=0: x_out<=sreg MSB; sreg shifts left; cnt--; first_bit<=0; last_bit<=(cnt==1).
- SHIFT, cnt==0 (last bit on x_out), in priority order:
  - (a) hold_full: load hold into the shifter exactly as in the IDLE load; clear hold_full; stay SHIFT.
  - (b) hold empty and transfer this edge: load in_data directly; stay SHIFT.
  - (c) neither: x_out<=IDLE_BIT; bit_valid, last_bit<=0; go IDLE.
- SHIFT, cnt!=0 and transfer: in_data is captured into hold; hold_full<=1.
- Simultaneous case: cnt==0 with hold_full and in_valid. Hold moves to the shifter. in_ready is 0 that cycle, so no new accept; in_ready rises the next cycle.
- Sustained throughput: one word per WIDTH cycles, with no idle bit between words.
- first_bit and last_bit are never both 1 (WIDTH>=2).

Optional Feature:
SER_LSB_FIRST_EN
- Defined: bit 0 is emitted first. The shifter shifts right and x_out takes sreg LSB. Loads drive x_out<=in_data[0].
- Undefined: MSB first as above. Handshake, timing and flags are identical in both builds.

Decomposition:
- Shared package ser_pkg holds the state typedef (IDLE, SHIFT) and the default IDLE_BIT constant.
- No sub-module; the holding register is a few lines inside the block.

Test Plan:
- WIDTH=8, single word 8'h79 (0111_1001): x_out = 0,1,1,1,1,0,0,1 on cycles 1..8 after accept. first_bit on cycle 1, last_bit on cycle 8. Cycle 9: x_out=0, bit_valid=0, busy=0. Downstream detector raises z one cycle after the final 1.
- Back-to-back: in_valid held high with 8'hFF then 8'h39. Result: 16 consecutive bit_valid cycles, no gap; in_ready low from the hold capture until the cnt==0 handover.
- Backpressure: three words offered continuously. Third waits with in_ready=0 until word 2 moves from hold to the shifter; all 24 bits are in order.
- Reset mid-word: assert rst during bit 4 of 8'hF0. x_out=0, bit_valid=0 and in_ready=1 immediately; the next word starts cleanly from its first bit.
- Idle between words: accept 8'h80, wait 3 cycles, accept 8'h01. x_out is idle 0 with bit_valid=0 in the gap, and first_bit marks the second word.
- SER_LSB_FIRST_EN build, 8'h79: x_out = 1,0,0,1,1,1,1,0. WIDTH=2 build: 2'b10 then 2'b01 back-to-back gives 1,0,0,1.
